line_buffer_ctrl: RTL and testbench

//  Sequences one dual-port RAM (DATA_WIDTH x 2**(LINE_SEL_WIDTH+LINE_ADDR_WIDTH)) as a ring of
//  2**LINE_SEL_WIDTH video lines for the scaler's vertical interpolation stage.

---
 rtl/line_buffer_ctrl.sv | 150 +++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: runs one dual-port RAM as a ring of 2**LINE_SEL_WIDTH video lines.
// Port A takes pixel writes from the input stream. Port B serves random reads from
// the vertical interpolator. The controller tracks filled and free lines, applies
// input backpressure and validates read requests.
// Optional feature: define LINE_BUF_ERR_CNT_EN to add a saturating err_cnt output.
module line_buffer_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int LINE_ADDR_WIDTH = 11,
  parameter int LINE_SEL_WIDTH  = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     frame_start,
  input  logic [LINE_ADDR_WIDTH-1:0]               line_width,
  input  logic                                     in_valid,
  input  logic [DATA_WIDTH-1:0]                    in_data,
  output logic                                     in_ready,
  input  logic                                     rd_req,
  input  logic [LINE_SEL_WIDTH-1:0]                rd_line_ofs,
  input  logic [LINE_ADDR_WIDTH-1:0]               rd_x,
  output logic                                     rd_valid,
  output logic                                     rd_err,
  output logic [DATA_WIDTH-1:0]                    rd_data,
  input  logic                                     line_release,
  output logic [LINE_SEL_WIDTH:0]                  lines_filled,
  output logic [LINE_SEL_WIDTH+LINE_ADDR_WIDTH-1:0] ram_addrA,
  output logic [DATA_WIDTH-1:0]                    ram_dataA,
  output logic                                     ram_weA,
  output logic [LINE_SEL_WIDTH+LINE_ADDR_WIDTH-1:0] ram_addrB,
  output logic                                     ram_weB,
  input  logic [DATA_WIDTH-1:0]                    ram_qB
`ifdef LINE_BUF_ERR_CNT_EN
  ,
  output logic [15:0]                              err_cnt
`endif
);

  localparam logic [LINE_SEL_WIDTH:0] FULL = {1'b1, {LINE_SEL_WIDTH{1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state;
  logic [LINE_ADDR_WIDTH-1:0]  width;
  logic [LINE_ADDR_WIDTH-1:0]  wr_x;
  logic [LINE_SEL_WIDTH-1:0]   wr_line;
  logic [LINE_SEL_WIDTH-1:0]   rd_base;
  logic [LINE_SEL_WIDTH:0]     filled;

  logic                        running;
  logic                        wr_en;
  logic                        line_done;
  logic                        rel_ok;
  logic                        rd_ok;
  logic [LINE_SEL_WIDTH-1:0]   rd_line;

  assign lines_filled = filled;
  assign rd_data      = ram_qB;
  assign ram_weB      = 1'b0;

  // Handshake, read validation and same-cycle RAM port drive.
  // A flush on frame_start takes priority, so writes and reads are suppressed in that cycle.
  always_comb begin
    running   = (state == RUN);
    in_ready  = running && (filled < FULL);
    wr_en     = in_valid && in_ready && !frame_start;
    line_done = wr_en && (wr_x == width - 1'b1);
    rel_ok    = line_release && (filled != '0);
    rd_ok     = rd_req && running && !frame_start &&
                ({1'b0, rd_line_ofs} < filled) && (rd_x < width);
    rd_line   = rd_base + rd_line_ofs;
    ram_weA   = wr_en;
    ram_addrA = {wr_line, wr_x};
    ram_dataA = wr_en ? in_data : '0;
    ram_addrB = rd_ok ? {rd_line, rd_x} : '0;
  end

  // Frame FSM together with the write pointer, ring base, fill count and read status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      width    <= '0;
      wr_x     <= '0;
      wr_line  <= '0;
      rd_base  <= '0;
      filled   <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_err   <= rd_req && !rd_ok;
      if (frame_start) begin
        state   <= (line_width != '0) ? RUN : IDLE;
        width   <= line_width;
        wr_x    <= '0;
        wr_line <= '0;
        rd_base <= '0;
        filled  <= '0;
      end else begin
        if (wr_en) begin
          if (line_done) begin
            wr_x    <= '0;
            wr_line <= wr_line + 1'b1;
          end else begin
            wr_x <= wr_x + 1'b1;
          end
        end
        if (rel_ok) begin
          rd_base <= rd_base + 1'b1;
        end
        // Completion and release in the same cycle cancel out.
        case ({line_done, rel_ok})
          2'b10:   filled <= filled + 1'b1;
          2'b01:   filled <= filled - 1'b1;
          default: filled <= filled;
        endcase
      end
    end
  end

`ifdef LINE_BUF_ERR_CNT_EN
  logic        rd_bad;
  logic        rel_bad;
  logic        in_bad;
  logic [1:0]  ev;
  logic [16:0] err_sum;

  // Up to three distinct error events can occur in one cycle; all of them are counted.
  always_comb begin
    rd_bad  = rd_req && !rd_ok;
    rel_bad = line_release && (filled == '0);
    in_bad  = in_valid && !in_ready && running;
    ev      = {1'b0, rd_bad} + {1'b0, rel_bad} + {1'b0, in_bad};
    err_sum = {1'b0, err_cnt} + 17'(ev);
  end

  // Saturating error counter, cleared at each frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (frame_start) begin
      err_cnt <= '0;
    end else if (err_sum[16]) begin
      err_cnt <= '1;
    end else begin
      err_cnt <= err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Testbench for line_buffer_ctrl: directed stimulus, a behavioural RAM, and a model
// that tracks the frame as a flat pixel stream (pixels accepted, lines released).
module tb_line_buffer_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 11;
  localparam int SW    = 2;
  localparam int LINES = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic [AW-1:0]     line_width;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              rd_req;
  logic [SW-1:0]     rd_line_ofs;
  logic [AW-1:0]     rd_x;
  logic              rd_valid;
  logic              rd_err;
  logic [DW-1:0]     rd_data;
  logic              line_release;
  logic [SW:0]       lines_filled;
  logic [SW+AW-1:0]  ram_addrA;
  logic [DW-1:0]     ram_dataA;
  logic              ram_weA;
  logic [SW+AW-1:0]  ram_addrB;
  logic              ram_weB;
  logic [DW-1:0]     ram_qB;
`ifdef LINE_BUF_ERR_CNT_EN
  logic [15:0]       err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  line_buffer_ctrl #(.DATA_WIDTH(DW), .LINE_ADDR_WIDTH(AW), .LINE_SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_width(line_width),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_req(rd_req), .rd_line_ofs(rd_line_ofs), .rd_x(rd_x),
    .rd_valid(rd_valid), .rd_err(rd_err), .rd_data(rd_data),
    .line_release(line_release), .lines_filled(lines_filled),
    .ram_addrA(ram_addrA), .ram_dataA(ram_dataA), .ram_weA(ram_weA),
    .ram_addrB(ram_addrB), .ram_weB(ram_weB), .ram_qB(ram_qB)
`ifdef LINE_BUF_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered port-B read.
  logic [DW-1:0] mem [0:(1<<(SW+AW))-1];
  always @(posedge clk) begin
    if (ram_weA) mem[ram_addrA] <= ram_dataA;
    ram_qB <= mem[ram_addrB];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame as a pixel stream.
  bit             m_run;
  int             m_w;
  int             m_px;
  int             m_rel;
  int             m_err;
  logic [DW-1:0]  m_pix [int];
  bit             e_rv, e_re;
  logic [DW-1:0]  e_rdata;

  function automatic int m_filled();
    if (m_w == 0) return 0;
    return m_px / m_w - m_rel;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  fill;
    bit  ready, acc;
    int  ev;
    if (!rst_n) begin
      m_run = 0; m_w = 0; m_px = 0; m_rel = 0; m_err = 0;
      m_pix.delete();
      e_rv = 0; e_re = 0; e_rdata = '0;
    end else begin
      fill  = m_filled();
      ready = m_run && fill < LINES;
      acc   = rd_req && m_run && !frame_start &&
              int'(rd_line_ofs) < fill && int'(rd_x) < m_w;
      e_rv  = acc;
      e_re  = rd_req && !acc;
      if (acc) e_rdata = m_pix[(m_rel + int'(rd_line_ofs)) * m_w + int'(rd_x)];
      ev = int'(rd_req && !acc) + int'(line_release && fill == 0) +
           int'(in_valid && !ready && m_run);
      if (frame_start) begin
        m_run = (line_width != 0);
        m_w   = int'(line_width);
        m_px  = 0; m_rel = 0; m_err = 0;
        m_pix.delete();
      end else begin
        m_err = (m_err + ev > 65535) ? 65535 : m_err + ev;
        if (in_valid && ready) begin
          m_pix[m_px] = in_data;
          m_px++;
        end
        if (line_release && fill != 0) m_rel++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    int fill;
    bit exp_ready, exp_we;
    if (rst_n) begin
      fill      = m_filled();
      exp_ready = m_run && fill < LINES;
      exp_we    = in_valid && exp_ready && !frame_start;
      chk("in_ready", in_ready, exp_ready);
      chk("lines_filled", lines_filled, fill);
      chk("ram_weA", ram_weA, exp_we);
      chk("ram_weB", ram_weB, 0);
      if (exp_we) begin
        chk("ram_addrA", ram_addrA, ((m_px / m_w) % LINES) * (1 << AW) + m_px % m_w);
        chk("ram_dataA", ram_dataA, in_data);
      end
      chk("rd_valid", rd_valid, e_rv);
      chk("rd_err", rd_err, e_re);
      if (e_rv) chk("rd_data", rd_data, e_rdata);
`ifdef LINE_BUF_ERR_CNT_EN
      chk("err_cnt", err_cnt, m_err);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int w);
    frame_start = 1'b1;
    line_width  = AW'(w);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read(input int ofs, input int x);
    rd_req      = 1'b1;
    rd_line_ofs = SW'(ofs);
    rd_x        = AW'(x);
    tick();
    rd_req      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; line_width = '0; in_valid = 1'b0; in_data = '0;
    rd_req = 1'b0; rd_line_ofs = '0; rd_x = '0; line_release = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_filled", lines_filled, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_weA", ram_weA, 0);
    rst_n = 1'b1;
    tick();

    // Fill the ring with width 4.
    start_frame(4);
    chk("run_in_ready", in_ready, 1);
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    chk("full_filled", lines_filled, 4);
    chk("full_in_ready", in_ready, 0);
    push(8'hEE);

    read(2, 3);
    chk("full_rd_valid", rd_valid, 1);
    chk("full_rd_data", rd_data, 8'h1B);

    line_release = 1'b1; tick(); line_release = 1'b0;
    chk("rel_filled", lines_filled, 3);

    // 17th pixel lands at the wrapped slot, line 0 x 0.
    in_valid = 1'b1; in_data = 8'h20;
    #1;
    chk("wrap_weA", ram_weA, 1);
    chk("wrap_addrA", ram_addrA, 0);
    tick();
    push(8'h21);
    push(8'h22);
    in_valid = 1'b1; in_data = 8'h23; line_release = 1'b1;
    tick();
    in_valid = 1'b0; line_release = 1'b0;
    chk("done_rel_filled", lines_filled, 3);

    read(2, 1);
    chk("wrap_rd_valid", rd_valid, 1);
    chk("wrap_rd_data", rd_data, 8'h21);

    line_release = 1'b1; tick(); tick(); line_release = 1'b0;
    chk("one_filled", lines_filled, 1);
    read(1, 0);
    chk("ofs_rd_err", rd_err, 1);
    chk("ofs_rd_valid", rd_valid, 0);
    read(0, 4);
    chk("x_rd_err", rd_err, 1);
    chk("x_rd_valid", rd_valid, 0);
    read(0, 3);
    chk("last_rd_valid", rd_valid, 1);
    chk("last_rd_data", rd_data, 8'h23);

    line_release = 1'b1; tick(); tick(); line_release = 1'b0;
    chk("empty_filled", lines_filled, 0);

    // Flush mid-line.
    start_frame(4);
    for (int i = 0; i < 14; i++) push(8'h40 + 8'(i));
    chk("mid_filled", lines_filled, 3);
    start_frame(4);
    chk("flush_filled", lines_filled, 0);
    chk("flush_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("flush_addrA", ram_addrA, 0);
    tick();
    in_valid = 1'b0;

    // Odd width, sweep of reads across valid and invalid positions.
    start_frame(3);
    for (int i = 0; i < 7; i++) push(8'(7 * i + 3));
    read(1, 2);
    chk("w3_rd_valid", rd_valid, 1);
    chk("w3_rd_data", rd_data, 8'h26);
    for (int o = 0; o < 3; o++)
      for (int x = 0; x < 4; x++) read(o, x);

    // Width 0 returns to idle; reads are rejected there.
    start_frame(0);
    chk("idle_in_ready", in_ready, 0);
    read(0, 0);
    chk("idle_rd_err", rd_err, 1);
    read(0, 0);
    read(0, 0);
`ifdef LINE_BUF_ERR_CNT_EN
    chk("idle_err_cnt", err_cnt, 3);
`endif
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
